// File: rtl/mips_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads imem and feeds decode via a 2-entry prefetch queue.
// Optional build macro FETCH_PERF_EN adds saturating pop/stall performance counters.
module mips_fetch_ctrl #(
  parameter int unsigned          PC_W       = 32,
  parameter int unsigned          INSTR_W    = 16,
  parameter logic [PC_W-1:0]      RESET_PC   = '0,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = INSTR_W'(16'hFFFF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_e;

  // Invalid entries are kept all-zero so the head drives zeros straight out.
  typedef struct packed {
    logic               vld;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_e            state_q, state_d;
  entry_t            head_q, head_d, tail_q, tail_d;
  entry_t            push_entry;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              halted_q, halted_d;
  logic              pop, redirect, push, halt_pop;

  assign push_entry = {1'b1, fetch_pc_q, imem_instr};

  // Handshake and priority decode; redirect suppresses any push.
  always_comb begin
    pop      = head_q.vld && out_ready;
    redirect = redirect_valid && ((state_q == S_RUN) || (state_q == S_DRAIN));
    push     = (state_q == S_RUN) && !redirect && (!tail_q.vld || pop);
    halt_pop = (state_q == S_DRAIN) && pop && (head_q.instr == HALT_INSTR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN: begin
        if (redirect)                                state_d = S_RUN;
        else if (push && (imem_instr == HALT_INSTR)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (redirect)      state_d = S_RUN;
        else if (halt_pop) state_d = S_HALTED;
      end
      S_HALTED: if (start) state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  // Queue shift/fill, fetch PC and halt flag next values.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    if (pop) begin
      head_d = tail_q;
      tail_d = '0;
    end
    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc;
    end else if (push) begin
      if (!head_d.vld) head_d = push_entry;
      else             tail_d = push_entry;
      fetch_pc_d = fetch_pc_q + PC_W'(1);
    end
    if (halt_pop && !redirect) halted_d = 1'b1;
    if ((state_q == S_HALTED) && start) begin
      halted_d   = 1'b0;
      fetch_pc_d = RESET_PC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      fetch_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = head_q.vld;
  assign out_pc    = head_q.pc;
  assign out_instr = head_q.instr;
  assign halted    = halted_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop && (fetch_cnt_q != 32'hFFFF_FFFF))
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (head_q.vld && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
